neuron_core_sequencer: RTL and testbench
========================================

Name: neuron_core_sequencer

Overview:
Layer scheduler that time-multiplexes one polynomial neuron core across NumNeurons coefficient sets, all evaluated on the same scalar input. For each neuron it fetches 20 coefficients plus the offset from an external coefficient ROM and writes them, the input and Start into the core through the core's CPU slave port. It then polls the core for Listo/Error, reads the result and emits it with its neuron index. It replaces CPU-driven sequencing of the core so a whole layer runs from one `go` pulse.

Parameters:
Width, 32, data width (matches core fixed-point word)
NumNeurons, 8, coefficient sets evaluated per run (1..255)
NumCoeff, 21, words per neuron: Coeff00..Coeff19 at core addresses 0..19, Offset at 20
AddrInput, 21, core address of InDato register
AddrStart, 22, core address of Start register
AddrStatus, 23, core read address: bit0 = Listo, bit1 = Error
AddrResult, 24, core read address of stored activation output
PollLimit, 255, maximum status polls per neuron before timeout
RomAddrWidth, 8, coefficient ROM address width

Ports:
CLK  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
go  in  1  start a layer run; sampled only in IDLE
in_x  in  Width  layer input, latched when go is accepted
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
error  out  1  sticky OR of res_error over the run; cleared on accepted go
rom_addr  out  RomAddrWidth  coefficient ROM address; neuron n word k at n*NumCoeff+k
rom_data  in  Width  ROM data, valid 1 cycle after rom_addr
core_write  out  1  core slave write strobe
core_read  out  1  core slave read strobe
core_address  out  9  core slave address
core_writedata  out  Width  core slave write data
core_readdata  in  Width  core slave read data, combinational, valid in the same cycle as core_read
res_valid  out  1  one-cycle pulse with result
res_index  out  8  neuron index of result
res_data  out  Width  neuron result
res_error  out  1  result invalid (core Error or timeout)

Behaviour:
- Reset (any state, including mid-run): next edge returns the FSM to IDLE.
  - busy, done, error, res_valid, res_error, core_write and core_read all go to 0.
  - rom_addr, core_address, core_writedata, res_index and res_data all go to 0.
  - The sequencer never resets the core.
- All outputs are registered.
- core_write and core_read are never high in the same cycle.
- IDLE: on go = 1, latch in_x, clear error, set neuron counter n = 0, go to LOAD; busy = 1 from the next cycle.
  - go is ignored while busy.
- LOAD: lasts NumCoeff+1 cycles, local step j = 0..NumCoeff.
  - For j < NumCoeff: rom_addr = n*NumCoeff + j.
  - For j >= 1: core_write = 1, core_address = j-1, core_writedata = rom_data.
- WRX (1 cycle): write latched x to AddrInput.
- START (1 cycle): write 1 to AddrStart.
- POLL: core_read = 1 at AddrStatus every cycle; the poll counter increments on each poll.
  - Status bit0 = 1 → go to RESULT; capture status bit1 as core error.
  - Bit0 = 0 after PollLimit polls → timeout; go to EMIT with res_error = 1 and res_data = 0.
- RESULT (1 cycle): core_read at AddrResult, capture core_readdata.
- EMIT (1 cycle):
  - res_valid = 1, res_index = n, res_data as captured, res_error = core error | timeout.
  - error |= res_error.
  - If n = NumNeurons-1 go to DONE; otherwise increment n and go to LOAD.
- DONE (1 cycle): done = 1, busy still 1; IDLE next cycle with busy = 0.
- Listo and Error both set: the result is still read and reported, with res_error = 1.
- Latency per neuron = NumCoeff + 1 + 1 + 1 + P + 1 + 1 cycles, where P = polls (P >= 1). Default with P = 1 is 27.
- Total run latency = NumNeurons × per-neuron latency, plus 1 cycle for DONE.
- in_x changes during a run have no effect.
- res_data, res_index and res_error hold their values until the next EMIT.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0, FSM IDLE. A go during reset is not accepted.
- NumNeurons = 2, ROM word a = a+100, in_x = 0x00800000, core model asserts Listo on the 3rd poll, result = 0x11 then 0x22:
  - writes go to addresses 0..20 with data 100..120, then 21 ← 0x00800000, then 22 ← 1;
  - second neuron's writes carry data 121..141;
  - res_valid pulses with (0, 0x11) and (1, 0x22);
  - done pulses once, in cycle 2×29+1 after go acceptance.
- PollLimit = 4, core never sets Listo → exactly 4 status reads, then res_valid with res_error = 1 and res_data = 0; error = 1 at done; the next neuron is still processed.
- Status = 0x3, result 0x55 → res_data = 0x55, res_error = 1, error sticky until the next accepted go, then cleared.
- go pulsed again at cycle 5 of a run, and in_x changed → no restart; all AddrInput writes use the original x.
- reset asserted mid-LOAD (j = 10) → next cycle core_write = 0, busy = 0. A later go restarts at neuron 0, rom_addr 0.

Source files
------------

// File: rtl/neuron_core_sequencer.sv
// neuron_core_sequencer
//   Runs one polynomial neuron core over NumNeurons coefficient sets, all on
//   the same scalar input. For each neuron it streams 20 coefficients plus the
//   offset from the coefficient ROM into the core, writes the input and Start,
//   polls Listo/Error, reads the result and emits it with its neuron index.
//   A whole layer runs from one go pulse.
//
// Ports
//   CLK, reset       rising-edge clock, synchronous active-high reset
//   go, in_x         start request (IDLE only) and layer input latched on it
//   busy, done       run in progress / one-cycle end-of-run pulse
//   error            sticky OR of res_error over the run
//   rom_addr/data    coefficient ROM; data sampled one cycle after the address
//   core_*           CPU slave port of the neuron core (readdata combinational)
//   res_*            per-neuron result pulse, index, data and error flag
//
// state  | meaning
// IDLE   | waiting for go
// LOAD   | ROM -> core coefficient stream, step j = 0..NumCoeff
// WRX    | write latched x to the core input register
// START  | write 1 to the core start register
// POLL   | read status each cycle until Listo or poll limit
// RESULT | read the activation output
// EMIT   | present the result for neuron n
// DONE   | end-of-run pulse
module neuron_core_sequencer #(
  parameter int Width        = 32,
  parameter int NumNeurons   = 8,
  parameter int NumCoeff     = 21,
  parameter int AddrInput    = 21,
  parameter int AddrStart    = 22,
  parameter int AddrStatus   = 23,
  parameter int AddrResult   = 24,
  parameter int PollLimit    = 255,
  parameter int RomAddrWidth = 8
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    go,
  input  logic [Width-1:0]        in_x,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [RomAddrWidth-1:0] rom_addr,
  input  logic [Width-1:0]        rom_data,
  output logic                    core_write,
  output logic                    core_read,
  output logic [8:0]              core_address,
  output logic [Width-1:0]        core_writedata,
  input  logic [Width-1:0]        core_readdata,
  output logic                    res_valid,
  output logic [7:0]              res_index,
  output logic [Width-1:0]        res_data,
  output logic                    res_error
);

  localparam int JW = $clog2(NumCoeff + 1);
  localparam int PW = $clog2(PollLimit + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRX, S_START, S_POLL, S_RESULT, S_EMIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [JW-1:0]     j_q, j_d;
  logic [7:0]        n_q, n_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [Width-1:0]  x_q, x_d;
  logic              cerr_q, cerr_d;

  logic                    busy_d, done_d, error_d;
  logic [RomAddrWidth-1:0] rom_addr_d;
  logic                    core_write_d, core_read_d;
  logic [8:0]              core_address_d;
  logic [Width-1:0]        core_writedata_d;
  logic                    res_valid_d, res_error_d;
  logic [7:0]              res_index_d;
  logic [Width-1:0]        res_data_d;

  always_comb begin
    state_d          = state_q;
    j_d              = j_q;
    n_d              = n_q;
    poll_d           = poll_q;
    x_d              = x_q;
    cerr_d           = cerr_q;
    error_d          = error;
    res_index_d      = res_index;
    res_data_d       = res_data;
    res_error_d      = res_error;
    rom_addr_d       = rom_addr;
    core_address_d   = core_address;
    core_writedata_d = core_writedata;
    core_write_d     = 1'b0;
    core_read_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_LOAD;
          j_d     = '0;
          n_d     = '0;
          x_d     = in_x;
          error_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (j_q == JW'(NumCoeff)) state_d = S_WRX;
        else                      j_d     = j_q + 1'b1;
      end
      S_WRX:   state_d = S_START;
      S_START: begin
        state_d = S_POLL;
        poll_d  = PW'(1);
      end
      S_POLL: begin
        if (core_readdata[0]) begin
          state_d = S_RESULT;
          cerr_d  = core_readdata[1];
        end else if (poll_q == PW'(PollLimit)) begin
          state_d     = S_EMIT;
          res_index_d = n_q;
          res_data_d  = '0;
          res_error_d = 1'b1;
          error_d     = 1'b1;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      S_RESULT: begin
        state_d     = S_EMIT;
        res_index_d = n_q;
        res_data_d  = core_readdata;
        res_error_d = cerr_q;
        error_d     = error | cerr_q;
      end
      S_EMIT: begin
        if (n_q == 8'(NumNeurons - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
          n_d     = n_q + 1'b1;
          j_d     = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so the registered
    // strobes line up with the state they belong to.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    res_valid_d = (state_d == S_EMIT);

    case (state_d)
      S_LOAD: begin
        if (j_d < JW'(NumCoeff))
          rom_addr_d = RomAddrWidth'(int'(n_d) * NumCoeff + int'(j_d));
        // rom_data now holds the word addressed in the previous step
        if (j_d != '0) begin
          core_write_d     = 1'b1;
          core_address_d   = 9'(j_d) - 9'd1;
          core_writedata_d = rom_data;
        end
      end
      S_WRX: begin
        core_write_d     = 1'b1;
        core_address_d   = 9'(AddrInput);
        core_writedata_d = x_q;
      end
      S_START: begin
        core_write_d     = 1'b1;
        core_address_d   = 9'(AddrStart);
        core_writedata_d = Width'(1);
      end
      S_POLL: begin
        core_read_d    = 1'b1;
        core_address_d = 9'(AddrStatus);
      end
      S_RESULT: begin
        core_read_d    = 1'b1;
        core_address_d = 9'(AddrResult);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q        <= S_IDLE;
      j_q            <= '0;
      n_q            <= '0;
      poll_q         <= '0;
      x_q            <= '0;
      cerr_q         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      rom_addr       <= '0;
      core_write     <= 1'b0;
      core_read      <= 1'b0;
      core_address   <= '0;
      core_writedata <= '0;
      res_valid      <= 1'b0;
      res_index      <= '0;
      res_data       <= '0;
      res_error      <= 1'b0;
    end else begin
      state_q        <= state_d;
      j_q            <= j_d;
      n_q            <= n_d;
      poll_q         <= poll_d;
      x_q            <= x_d;
      cerr_q         <= cerr_d;
      busy           <= busy_d;
      done           <= done_d;
      error          <= error_d;
      rom_addr       <= rom_addr_d;
      core_write     <= core_write_d;
      core_read      <= core_read_d;
      core_address   <= core_address_d;
      core_writedata <= core_writedata_d;
      res_valid      <= res_valid_d;
      res_index      <= res_index_d;
      res_data       <= res_data_d;
      res_error      <= res_error_d;
    end
  end

endmodule

// File: tb/tb_neuron_core_sequencer.sv
// Bench for neuron_core_sequencer: two neurons, poll limit 4, ROM word a = a+100,
// behavioural core slave with per-neuron Listo poll number, Error bit and result.
module tb_neuron_core_sequencer;

  logic        CLK = 1'b0;
  logic        reset, go;
  logic [31:0] in_x;
  logic        busy, done, error;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        core_write, core_read;
  logic [8:0]  core_address;
  logic [31:0] core_writedata, core_readdata;
  logic        res_valid, res_error;
  logic [7:0]  res_index;
  logic [31:0] res_data;

  always #5 CLK = ~CLK;

  neuron_core_sequencer #(.NumNeurons(2), .PollLimit(4)) dut (
    .CLK(CLK), .reset(reset), .go(go), .in_x(in_x),
    .busy(busy), .done(done), .error(error),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .core_write(core_write), .core_read(core_read),
    .core_address(core_address), .core_writedata(core_writedata),
    .core_readdata(core_readdata),
    .res_valid(res_valid), .res_index(res_index),
    .res_data(res_data), .res_error(res_error)
  );

  assign rom_data = 32'(rom_addr) + 32'd100;

  // core model
  int          listo_at [2];
  logic        errbit   [2];
  logic [31:0] result   [2];
  int          polls = 0;
  int          starts = 0;
  int          nsel;
  logic        st_listo;

  always_comb begin
    core_readdata = '0;
    nsel          = (starts > 0) ? ((starts - 1) % 2) : 0;
    st_listo      = (listo_at[nsel] != 0) && (polls + 1 >= listo_at[nsel]);
    if (core_read && core_address == 9'd23)
      core_readdata = {30'd0, errbit[nsel], st_listo};
    else if (core_read && core_address == 9'd24)
      core_readdata = result[nsel];
  end

  always @(posedge CLK) begin
    if (!busy) starts <= 0;
    else if (core_write && core_address == 9'd22) starts <= starts + 1;
    if (core_write && core_address == 9'd22) polls <= 0;
    else if (core_read && core_address == 9'd23) polls <= polls + 1;
  end

  // run record
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          n_wr;
  logic [31:0] ev_idx [4];
  logic [31:0] ev_data [4];
  logic [31:0] ev_err [4];
  int          n_ev;
  int          rd_stat [2];
  int          done_cnt, done_cyc, both_cnt;
  logic        err_at_done, err_c1;
  logic [7:0]  rom_c1, rom_c30;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_layer(input logic [31:0] x, input int regos_cyc,
                           input logic [31:0] x2, input int stop_cyc);
    int cyc;
    n_wr = 0; n_ev = 0; done_cnt = 0; done_cyc = -1; both_cnt = 0;
    rd_stat[0] = 0; rd_stat[1] = 0;
    for (int i = 0; i < 64; i++) begin wr_addr[i] = '1; wr_data[i] = '1; end
    for (int i = 0; i < 4; i++) begin ev_idx[i] = '1; ev_data[i] = '1; ev_err[i] = '1; end
    @(negedge CLK);
    in_x = x;
    go   = 1'b1;
    for (cyc = 1; cyc <= 150; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) begin
        go   = 1'b0;
        in_x = 32'h0;
      end
      if (cyc == regos_cyc) begin
        go   = 1'b1;
        in_x = x2;
      end else if (regos_cyc != 0 && cyc == regos_cyc + 1) begin
        go = 1'b0;
      end
      if (core_write && core_read) both_cnt++;
      if (core_write && n_wr < 64) begin
        wr_addr[n_wr] = 32'(core_address);
        wr_data[n_wr] = core_writedata;
        n_wr++;
      end
      if (core_read && core_address == 9'd23 && n_ev < 2) rd_stat[n_ev]++;
      if (res_valid && n_ev < 4) begin
        ev_idx[n_ev]  = 32'(res_index);
        ev_data[n_ev] = res_data;
        ev_err[n_ev]  = 32'(res_error);
        n_ev++;
      end
      if (done) begin
        done_cnt++;
        done_cyc    = cyc;
        err_at_done = error;
      end
      if (cyc == 1) begin
        rom_c1 = rom_addr;
        err_c1 = error;
      end
      if (cyc == 30) rom_c30 = rom_addr;
      if (cyc == stop_cyc) break;
      if (done_cnt > 0 && !busy) break;
    end
    if (stop_cyc == 0) chk("run_end_idle", 32'(busy), 0);
  endtask

  task automatic set_core(input int l0, input int l1, input logic e0, input logic e1,
                          input logic [31:0] r0, input logic [31:0] r1);
    listo_at[0] = l0; listo_at[1] = l1;
    errbit[0]   = e0; errbit[1]   = e1;
    result[0]   = r0; result[1]   = r1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    go    = 1'b1;
    in_x  = 32'hFFFF_FFFF;
    set_core(3, 3, 1'b0, 1'b0, 32'h11, 32'h22);
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    go    = 1'b0;
    chk("reset_ctl", 32'({busy, done, error, res_valid, res_error, core_write, core_read}), 0);
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_core_addr", 32'(core_address), 0);
    chk("reset_wdata", core_writedata, 0);
    chk("reset_res_index", 32'(res_index), 0);
    chk("reset_res_data", res_data, 0);
    @(negedge CLK);
    chk("go_in_reset_ignored", 32'(busy), 0);

    // normal two-neuron run, Listo on third poll
    run_layer(32'h0080_0000, 0, 32'h0, 0);
    chk("n_writes", 32'(n_wr), 46);
    for (int k = 0; k < 21; k++) begin
      chk("n0_coeff_addr", wr_addr[k], 32'(k));
      chk("n0_coeff_data", wr_data[k], 32'(100 + k));
      chk("n1_coeff_addr", wr_addr[23 + k], 32'(k));
      chk("n1_coeff_data", wr_data[23 + k], 32'(121 + k));
    end
    chk("n0_x_addr", wr_addr[21], 21);
    chk("n0_x_data", wr_data[21], 32'h0080_0000);
    chk("n0_start_addr", wr_addr[22], 22);
    chk("n0_start_data", wr_data[22], 1);
    chk("n1_x_data", wr_data[44], 32'h0080_0000);
    chk("n1_start_addr", wr_addr[45], 22);
    chk("n_results", 32'(n_ev), 2);
    chk("res0_index", ev_idx[0], 0);
    chk("res0_data", ev_data[0], 32'h11);
    chk("res0_err", ev_err[0], 0);
    chk("res1_index", ev_idx[1], 1);
    chk("res1_data", ev_data[1], 32'h22);
    chk("res1_err", ev_err[1], 0);
    chk("done_count", 32'(done_cnt), 1);
    chk("done_cycle", 32'(done_cyc), 59);
    chk("error_at_done", 32'(err_at_done), 0);
    chk("polls_n0", 32'(rd_stat[0]), 3);
    chk("polls_n1", 32'(rd_stat[1]), 3);
    chk("rd_wr_overlap", 32'(both_cnt), 0);
    chk("rom_addr_n0_j0", 32'(rom_c1), 0);
    chk("rom_addr_n1_j0", 32'(rom_c30), 21);
    @(negedge CLK);
    chk("res_data_held", res_data, 32'h22);

    // neuron 0 times out, neuron 1 answers on the first poll
    set_core(0, 1, 1'b0, 1'b0, 32'h99, 32'h33);
    run_layer(32'h0000_0007, 0, 32'h0, 0);
    chk("to_polls_n0", 32'(rd_stat[0]), 4);
    chk("to_polls_n1", 32'(rd_stat[1]), 1);
    chk("to_res0_data", ev_data[0], 0);
    chk("to_res0_err", ev_err[0], 1);
    chk("to_res1_index", ev_idx[1], 1);
    chk("to_res1_data", ev_data[1], 32'h33);
    chk("to_res1_err", ev_err[1], 0);
    chk("to_error_at_done", 32'(err_at_done), 1);
    chk("to_done_cycle", 32'(done_cyc), 57);

    // Listo and Error together on neuron 0
    set_core(2, 1, 1'b1, 1'b0, 32'h55, 32'h66);
    run_layer(32'h0000_0003, 0, 32'h0, 0);
    chk("ce_res0_data", ev_data[0], 32'h55);
    chk("ce_res0_err", ev_err[0], 1);
    chk("ce_res1_data", ev_data[1], 32'h66);
    chk("ce_res1_err", ev_err[1], 0);
    chk("ce_error_at_done", 32'(err_at_done), 1);
    repeat (3) @(negedge CLK);
    chk("error_sticky_idle", 32'(error), 1);

    // second go and new in_x mid-run are ignored; error cleared on accept
    set_core(3, 3, 1'b0, 1'b0, 32'h11, 32'h22);
    run_layer(32'h1234_5678, 5, 32'hCAFE_F00D, 0);
    chk("error_cleared_on_go", 32'(err_c1), 0);
    chk("regos_x_n0", wr_data[21], 32'h1234_5678);
    chk("regos_x_n1", wr_data[44], 32'h1234_5678);
    chk("regos_done_count", 32'(done_cnt), 1);
    chk("regos_done_cycle", 32'(done_cyc), 59);
    chk("regos_error_at_done", 32'(err_at_done), 0);

    // reset in LOAD step j = 10
    run_layer(32'h0000_0001, 0, 32'h0, 11);
    chk("midload_write", 32'(core_write), 1);
    chk("midload_addr", 32'(core_address), 9);
    reset = 1'b1;
    @(negedge CLK);
    chk("midreset_write", 32'(core_write), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_rom_addr", 32'(rom_addr), 0);
    reset = 1'b0;
    @(negedge CLK);

    run_layer(32'h0080_0000, 0, 32'h0, 0);
    chk("restart_rom_addr", 32'(rom_c1), 0);
    chk("restart_wr0_addr", wr_addr[0], 0);
    chk("restart_wr0_data", wr_data[0], 100);
    chk("restart_res0_index", ev_idx[0], 0);
    chk("restart_res0_data", ev_data[0], 32'h11);
    chk("restart_done_cycle", 32'(done_cyc), 59);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
